// File: rtl/axi_arb_pkg.sv
// -----------------------------------------------------------------------------
// axi_arb_pkg
// Shared definitions for the two-requester AXI4 read-port arbiter.
//   - ar_w / r_w     : payload width formulas; used by the arbiter to size its
//                      ports from its own parameters.
//   - AR_W .. MR_W   : the same widths at the default configuration
//                      (ID 8, address 32, data 128).
//   - ar_pld_t / r_pld_t and the m_* wrappers : field layout at the defaults.
//     The manager-side payloads add one source bit above the requester payload.
//   - mk_ar / mk_r / *_src : build payloads and pull fields out of them.
// -----------------------------------------------------------------------------
package axi_arb_pkg;

  localparam int ID_WIDTH_D   = 8;
  localparam int ADDR_WIDTH_D = 32;
  localparam int WIDTH_D      = 128;

  // AR payload: {arid, araddr, arlen[7:0], arsize[2:0], arburst[1:0]}
  function automatic int ar_w(input int id_w, input int addr_w);
    return id_w + addr_w + 13;
  endfunction

  // R payload: {rid, rdata, rresp[1:0], rlast}
  function automatic int r_w(input int id_w, input int data_w);
    return id_w + data_w + 3;
  endfunction

  localparam int AR_W  = ar_w(ID_WIDTH_D, ADDR_WIDTH_D);
  localparam int MAR_W = AR_W + 1;
  localparam int R_W   = r_w(ID_WIDTH_D, WIDTH_D);
  localparam int MR_W  = R_W + 1;

  typedef struct packed {
    logic [ID_WIDTH_D-1:0]   arid;
    logic [ADDR_WIDTH_D-1:0] araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
  } ar_pld_t;

  typedef struct packed {
    logic    src;
    ar_pld_t ar;
  } m_ar_pld_t;

  typedef struct packed {
    logic [ID_WIDTH_D-1:0] rid;
    logic [WIDTH_D-1:0]    rdata;
    logic [1:0]            rresp;
    logic                  rlast;
  } r_pld_t;

  typedef struct packed {
    logic   src;
    r_pld_t r;
  } m_r_pld_t;

  function automatic ar_pld_t mk_ar(input logic [ID_WIDTH_D-1:0] id,
                                    input logic [ADDR_WIDTH_D-1:0] addr,
                                    input logic [7:0] len);
    ar_pld_t p;
    p.arid    = id;
    p.araddr  = addr;
    p.arlen   = len;
    p.arsize  = 3'd4;
    p.arburst = 2'b01;
    return p;
  endfunction

  function automatic r_pld_t mk_r(input logic [ID_WIDTH_D-1:0] id,
                                  input logic [WIDTH_D-1:0] data,
                                  input logic last);
    r_pld_t p;
    p.rid   = id;
    p.rdata = data;
    p.rresp = 2'b00;
    p.rlast = last;
    return p;
  endfunction

  function automatic logic ar_src(input m_ar_pld_t p);
    return p.src;
  endfunction

  function automatic logic r_src(input m_r_pld_t p);
    return p.src;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant, purely combinational. The last-grant register
// lives in the parent so it only advances on an actual accept.
//   req        in  [1:0]  request bits
//   last_grant in  1      index of the most recently granted requester
//   gnt        out [1:0]  one-hot grant (or 0 when nothing requests)
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: assign a default first so every path drives gnt and no latch forms.
    gnt = req;
    if (&req) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/axi_rd_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_rr_arbiter
// Shares one AXI4 read port (AR + R) between two requesters. AR transactions
// are arbitrated round-robin and pass through one register stage; R beats are
// steered back by the source bit in the MSB of the manager-side RID.
// A per-requester counter caps outstanding bursts at MAX_OUTST; a sticky err
// flags an rlast beat for a requester with nothing outstanding.
//
// Optional feature, enabled by defining ARB_PERF_CNT_EN:
//   grant_cnt[i] counts AR accepts, stall_cnt[i] counts cycles with
//   s_arvalid[i]=1 and s_arready[i]=0. Both are 32-bit and wrap.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   s_arvalid/s_arready[1:0] per-requester AR handshake
//   s_ar_pld[1:0]            {arid, araddr, arlen, arsize, arburst}
//   s_rvalid/s_rready[1:0]   per-requester R handshake
//   s_r_pld                  shared {rid, rdata, rresp, rlast}
//   m_arvalid/m_arready      manager AR handshake
//   m_ar_pld                 {src, s_ar_pld[src]}
//   m_rvalid/m_rready        manager R handshake
//   m_r_pld                  {src, rid, rdata, rresp, rlast}
//   err                      sticky protocol error
//   grant_cnt, stall_cnt     performance counters (ARB_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module axi_rd_rr_arbiter #(
  parameter  int WIDTH      = 128,
  parameter  int ID_WIDTH   = 8,
  parameter  int ADDR_WIDTH = 32,
  parameter  int MAX_OUTST  = 8,
  localparam int AR_W       = axi_arb_pkg::ar_w(ID_WIDTH, ADDR_WIDTH),
  localparam int MAR_W      = AR_W + 1,
  localparam int R_W        = axi_arb_pkg::r_w(ID_WIDTH, WIDTH),
  localparam int MR_W       = R_W + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           s_arvalid,
  output logic [1:0]           s_arready,
  input  logic [1:0][AR_W-1:0] s_ar_pld,
  output logic [1:0]           s_rvalid,
  input  logic [1:0]           s_rready,
  output logic [R_W-1:0]       s_r_pld,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  output logic [MAR_W-1:0]     m_ar_pld,
  input  logic                 m_rvalid,
  output logic                 m_rready,
  input  logic [MR_W-1:0]      m_r_pld,
  output logic                 err
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [1:0][31:0]     grant_cnt,
  output logic [1:0][31:0]     stall_cnt
`endif
);

  // MAX_OUTST is limited to 255, so eight bits always hold the count.
  localparam int                CNT_W   = 8;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUTST);

  logic [1:0][CNT_W-1:0] cnt;
  logic                  last_grant;
  logic [1:0]            eligible;
  logic [1:0]            gnt;
  logic [1:0]            r_done;
  logic                  slot_free;
  logic                  accept;
  logic                  gidx;
  logic                  r_sel;
  logic                  r_last;

  // ---------------------------------------------------------------- AR path
  assign eligible[0] = s_arvalid[0] & (cnt[0] < CNT_MAX);
  assign eligible[1] = s_arvalid[1] & (cnt[1] < CNT_MAX);

  // The output register can take a new entry when empty or draining this cycle.
  assign slot_free = ~m_arvalid | m_arready;

  rr_arb2 u_rr_arb2 (
    .req        (eligible),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign s_arready = slot_free ? gnt : 2'b00;
  assign accept    = |s_arready;
  assign gidx      = s_arready[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_arvalid  <= 1'b0;
      m_ar_pld   <= '0;
      last_grant <= 1'b1;  // requester 0 wins the first tie
    end else if (accept) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      m_arvalid  <= 1'b1;
      m_ar_pld   <= {gidx, s_ar_pld[gidx]};
      last_grant <= gidx;
    end else if (m_arready) begin
      m_arvalid  <= 1'b0;
    end
  end

  // ----------------------------------------------------------------- R path
  assign r_sel    = m_r_pld[MR_W-1];
  assign r_last   = m_r_pld[0];
  assign s_rvalid = r_sel ? {m_rvalid, 1'b0} : {1'b0, m_rvalid};
  assign m_rready = s_rready[r_sel];
  assign s_r_pld  = m_r_pld[R_W-1:0];
  assign r_done   = (m_rvalid & m_rready & r_last) ? (r_sel ? 2'b10 : 2'b01) : 2'b00;

  // ------------------------------------------------- outstanding counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        unique case ({s_arready[i], r_done[i]})
          2'b10: cnt[i] <= cnt[i] + 1'b1;
          2'b01: begin
            if (cnt[i] == '0) err <= 1'b1;
            else              cnt[i] <= cnt[i] - 1'b1;
          end
          2'b11: begin
            // A burst accepted this cycle cannot already be completing, so
            // an rlast against an empty counter is still stray: flag it and
            // count only the new burst.
            if (cnt[i] == '0) begin
              err    <= 1'b1;
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  // ------------------------------------------------- performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s_arready[i])                 grant_cnt[i] <= grant_cnt[i] + 32'd1;
        if (s_arvalid[i] & ~s_arready[i]) stall_cnt[i] <= stall_cnt[i] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/axi_rd_rr_arbiter.md
Name: axi_rd_rr_arbiter

Overview:
- Shares one AXI4 read port (AR+R) between two read requesters, e.g. two memory-tester read engines on one DDR controller port.
- Round-robin arbitration per AR transaction; one register stage on AR; R beats routed back by an ID prefix bit.
- Per-requester outstanding-burst limit; sticky protocol-error flag.

Parameters:
- WIDTH, 128, R data width in bits
- ID_WIDTH, 8, requester-side ID width; manager-side ID is ID_WIDTH+1
- ADDR_WIDTH, 32, address width
- MAX_OUTST, 8, max outstanding read bursts per requester (1..255)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_arvalid  in  [1:0]  AR valid per requester
- s_arready  out  [1:0]  AR ready per requester
- s_ar_pld  in  [1:0][AR_W-1:0]  {arid,araddr,arlen,arsize,arburst} per requester
- s_rvalid  out  [1:0]  R valid per requester
- s_rready  in  [1:0]  R ready per requester
- s_r_pld  out  [R_W-1:0]  {rid,rdata,rresp,rlast}, shared bus, qualified by s_rvalid
- m_arvalid  out  1  downstream AR valid
- m_arready  in  1  downstream AR ready
- m_ar_pld  out  [MAR_W-1:0]  AR payload; arid = {src,s_arid}
- m_rvalid  in  1  downstream R valid
- m_rready  out  1  downstream R ready
- m_r_pld  in  [MR_W-1:0]  R payload; rid MSB = src
- err  out  1  sticky: R beat with rlast for a requester whose outstanding count is 0

Behaviour:
- Reset values: m_arvalid=0, m_ar_pld=0, err=0, outstanding counters=0, last_grant=1 (requester 0 wins first tie).
- Requester i is eligible when s_arvalid[i]=1 and cnt[i]<MAX_OUTST.
- AR slot free = ~m_arvalid | m_arready.
- When the slot is free and any requester is eligible:
  - Grant one requester: if only one is eligible, grant it; if both, grant ~last_grant.
  - Assert s_arready[g] in the same cycle (combinational from slot free and eligibility).
  - Load m_ar_pld={g,s_ar_pld[g]} and set m_arvalid=1 on the next edge; update last_grant=g.
- s_arready is never high for an ineligible requester; at most one bit is high.
- AR latency: 1 cycle from s_arvalid&s_arready to m_arvalid. Back-to-back accepts with m_arready held high give full throughput.
- m_ar_pld is stable while m_arvalid=1 and m_arready=0. m_arvalid drops when m_arready is seen and no new grant occurs.
- R path is purely combinational: sel=m_rid[ID_WIDTH]; s_rvalid[sel]=m_rvalid; the other bit is 0; m_rready=s_rready[sel]; s_r_pld passes through with rid MSB stripped.
- cnt[i]: +1 on AR accept from i, -1 on an R handshake with rlast and sel=i. Simultaneous +1 and -1 leave it unchanged.
- rlast for a requester with cnt=0: counter held at 0 and err set until reset.
- cnt saturates at MAX_OUTST by construction, since requests are masked when full.
- Reset mid-burst: all state cleared asynchronously. In-flight R beats after reset set err only if they carry rlast.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- With it, the block adds outputs grant_cnt [1:0][31:0] and stall_cnt [1:0][31:0], both reset to 0 and wrapping at 2^32:
  - grant_cnt[i] counts AR accepts from requester i.
  - stall_cnt[i] counts cycles with s_arvalid[i]=1 and s_arready[i]=0.
- Without it, these ports and counters do not exist; the remaining behaviour is identical.

Decomposition:
- Package axi_arb_pkg holds:
  - Width constants: AR_W=ID_WIDTH+ADDR_WIDTH+13, MAR_W=AR_W+1, R_W=ID_WIDTH+WIDTH+3, MR_W=R_W+1.
  - Packed struct typedefs ar_pld_t and r_pld_t.
  - Field-extract helper functions.
- Sub-module rr_arb2: a 2-way round-robin grant from request bits and last_grant, purely combinational. The last_grant register stays in the parent.

Test Plan:
- Requester 0 only, 4 ARs with m_arready=1 -> m_arvalid for 4 consecutive cycles, arid MSB=0; cnt[0]=4; 4 rlast beats return cnt[0] to 0.
- Both requesters continuously valid for 6 ARs -> grant order 0,1,0,1,0,1; ARB_PERF_CNT_EN build shows grant_cnt=3/3.
- m_arready=0 for 5 cycles with m_arvalid high -> m_ar_pld unchanged and s_arready=0; the first cycle m_arready=1 accepts the next grant.
- MAX_OUTST=2, requester 1 issues 3 ARs with no R returns -> third held, s_arready[1]=0; one rlast to requester 1 -> third accepted next cycle.
- R burst of 4 beats with rid MSB=1 and s_rready[1] toggling -> s_rvalid=2'b10 only; m_rready follows s_rready[1]; s_r_pld rid = low ID_WIDTH bits.
- Same cycle: AR accept and rlast for requester 0 -> cnt unchanged. Separately, rlast with cnt=0 -> err=1, held until rst_n low.
